// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 16-bit ALU among NUM_REQ requesters.
// Divide-by-zero requests are answered locally and never reach the ALU.
module alu_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [16*NUM_REQ-1:0]   req_a_i,
  input  logic [16*NUM_REQ-1:0]   req_b_i,
  input  logic [4*NUM_REQ-1:0]    req_fun_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [15:0]             alu_a_o,
  output logic [15:0]             alu_b_o,
  output logic [3:0]              alu_fun_o,
  input  logic [15:0]             alu_out_i,
  input  logic [3:0]              alu_flags_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [15:0]             rsp_data_o,
  output logic [3:0]              rsp_flags_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);

  localparam logic [3:0] FunNop = 4'b1111;
  localparam logic [3:0] FunDiv = 4'b0011;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [15:0]     alu_a_q, alu_b_q;
  logic [3:0]      alu_fun_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     rsp_data_q;
  logic [3:0]      rsp_flags_q;
  logic            rsp_err_q;

  logic            grant_en;
  logic            gnt_found;
  logic            gnt_fire;
  logic            gnt_div0;
  logic [ID_W-1:0] gnt_idx;
  logic [15:0]     gnt_a, gnt_b;
  logic [3:0]      gnt_fun;

  // Search above the pointer first, then wrap to the low indices.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid_i[j] && (j > 32'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid_i[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(j);
      end
    end
  end

  always_comb begin
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_fun = FunNop;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (gnt_idx == ID_W'(j)) begin
        gnt_a   = req_a_i[16*j +: 16];
        gnt_b   = req_b_i[16*j +: 16];
        gnt_fun = req_fun_i[4*j +: 4];
      end
    end
  end

  assign grant_en = (state_q == StIdle) || ((state_q == StResp) && rsp_ready_i);
  assign gnt_fire = grant_en && gnt_found;
  assign gnt_div0 = (gnt_fun == FunDiv) && (gnt_b == 16'd0);

  always_comb begin
    req_ready_o = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      req_ready_o[j] = gnt_fire && (gnt_idx == ID_W'(j));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FunNop;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          if (gnt_fire) begin
            alu_a_q  <= gnt_a;
            alu_b_q  <= gnt_b;
            rsp_id_q <= gnt_idx;
            ptr_q    <= gnt_idx;
            if (gnt_div0) begin
              alu_fun_q   <= FunNop;
              rsp_data_q  <= 16'hFFFF;
              rsp_flags_q <= 4'b1000;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              alu_fun_q   <= gnt_fun;
              rsp_valid_q <= 1'b0;
              state_q     <= StIssue;
            end
          end else if ((state_q == StResp) && rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          // ALU output reflects the op regs sampled during StIssue.
          rsp_data_q  <= alu_out_i;
          rsp_flags_q <= alu_flags_i;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_fun_o   = alu_fun_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed vectors, queue scoreboard checked by a response monitor,
// and a small registered ALU model standing in for the real ALU.
module tb_alu_rr_scheduler;

  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [63:0]   req_a, req_b;
  logic [15:0]   req_fun;
  logic [NR-1:0] req_ready;
  logic [15:0]   alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic [15:0]   alu_out = '0;
  logic [3:0]    alu_flags = '0;
  logic          rsp_valid, rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [15:0]   rsp_data;
  logic [3:0]    rsp_flags;
  logic          rsp_err, busy;

  int n_vec = 0;
  int n_fail = 0;
  int div0_seen = 0;
  logic [22:0] sb[$];

  logic [3:0] gr[$];
  int         gc[$];
  logic [3:0] one;
  int         n;

  alu_rr_scheduler #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_fun_i(req_fun), .req_ready_o(req_ready), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_fun_o(alu_fun), .alu_out_i(alu_out), .alu_flags_i(alu_flags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] alu_model(input logic [15:0] a, b, input logic [3:0] f);
    case (f)
      4'b0000: return {4'b1000, a + b};
      4'b0001: return {4'b1000, a - b};
      4'b0011: return {4'b1000, (b == 16'd0) ? 16'd0 : a / b};
      4'b0100: return {4'b0100, a & b};
      4'b0101: return {4'b0100, a | b};
      4'b0110: return {4'b0100, a ^ b};
      4'b1011: return {4'b0010, 14'd0, a > b, a == b};
      4'b1100: return {4'b0001, a << b[3:0]};
      default: return 20'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    {alu_flags, alu_out} <= alu_model(alu_a, alu_b, alu_fun);
    if (alu_fun == 4'b0011 && alu_b == 16'd0) div0_seen <= div0_seen + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h, expected no response", rsp_id,
                 rsp_data);
      end else begin
        check("rsp", {41'd0, rsp_id, rsp_data, rsp_flags, rsp_err}, {41'd0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_alu"}, {28'd0, alu_a, alu_b, alu_fun}, {28'd0, 32'd0, 4'hF});
    check({tag, "_rsp"}, {35'd0, req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err, busy},
          64'd0);
  endtask

  task automatic set_req(input int id, input logic [15:0] a, b, input logic [3:0] f);
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_fun[4*id +: 4] = f;
    req_valid[id]      = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic [15:0] d, input logic [3:0] f, input logic e);
    sb.push_back({2'(id), d, f, e});
  endtask

  // Called in the cycle after the grant; counts cycles until RSP_VALID (grant cycle = 0).
  task automatic wait_rsp(input string name, input int lat);
    int cnt;
    cnt = 1;
    while (!rsp_valid && cnt < 10) begin
      step();
      cnt++;
    end
    check(name, 64'(cnt), 64'(lat));
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while ((busy || rsp_valid) && cnt < 20) begin
      step();
      cnt++;
    end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_one(input string name, input int id, input logic [15:0] a, b,
                         input logic [3:0] f, afun, input logic [15:0] d, input logic [3:0] fl,
                         input logic e, input int lat);
    set_req(id, a, b, f);
    #1;
    check({name, "_grant"}, {60'd0, req_ready}, 64'd1 << id);
    push_exp(id, d, fl, e);
    step();
    req_valid[id] = 1'b0;
    check({name, "_aluops"}, {28'd0, alu_a, alu_b, alu_fun}, {28'd0, a, b, afun});
    wait_rsp({name, "_lat"}, lat);
    step();
    check({name, "_done"}, {62'd0, busy, rsp_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_fun = '0;
    rsp_ready = 1'b0;
    step();
    step();
    check_reset("reset");
    rst = 1'b0;
    step();
    check_reset("idle");

    // All four requesters valid continuously: order 0,1,2,3,0 one grant every 3 cycles.
    rsp_ready = 1'b1;
    set_req(0, 16'd1, 16'd10, 4'b0000);
    set_req(1, 16'd20, 16'd5, 4'b0001);
    set_req(2, 16'h00F0, 16'h0FF0, 4'b0100);
    set_req(3, 16'd3, 16'd4, 4'b1100);
    push_exp(0, 16'd11, 4'b1000, 1'b0);
    push_exp(1, 16'd15, 4'b1000, 1'b0);
    push_exp(2, 16'h00F0, 4'b0100, 1'b0);
    push_exp(3, 16'd48, 4'b0001, 1'b0);
    push_exp(0, 16'd11, 4'b1000, 1'b0);
    #1;
    for (int c = 0; c <= 12; c++) begin
      if (req_ready != '0) begin
        gr.push_back(req_ready);
        gc.push_back(c);
      end
      step();
    end
    req_valid = '0;
    check("rr_count", 64'(gr.size()), 64'd5);
    for (int k = 0; k < 5 && k < gr.size(); k++) begin
      one = 4'b0001 << (k % 4);
      check("rr_order", {60'd0, gr[k]}, {60'd0, one});
      check("rr_cycle", 64'(gc[k]), 64'(3 * k));
    end
    wait_idle("rr_idle");

    run_one("req1_add", 1, 16'd7, 16'd5, 4'b0000, 4'b0000, 16'd12, 4'b1000, 1'b0, 3);
    run_one("req2_cmp", 2, 16'd9, 16'd3, 4'b1011, 4'b1011, 16'd2, 4'b0010, 1'b0, 3);
    run_one("req2_nop", 2, 16'd9, 16'd3, 4'b1111, 4'b1111, 16'd0, 4'b0000, 1'b0, 3);
    run_one("req0_div0", 0, 16'd100, 16'd0, 4'b0011, 4'b1111, 16'hFFFF, 4'b1000, 1'b1, 1);
    run_one("req1_div", 1, 16'd100, 16'd7, 4'b0011, 4'b0011, 16'd14, 4'b1000, 1'b0, 3);

    // Backpressure: response held and no grant while RSP_READY is low.
    rsp_ready = 1'b0;
    set_req(1, 16'd5, 16'd6, 4'b0101);
    push_exp(1, 16'd7, 4'b0100, 1'b0);
    #1;
    step();
    req_valid[1] = 1'b0;
    set_req(3, 16'hFF00, 16'h0F0F, 4'b0110);
    wait_rsp("bp_lat", 3);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {36'd0, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err, req_ready},
            {36'd0, 1'b1, 2'd1, 16'd7, 4'b0100, 1'b0, 4'b0000});
      step();
    end
    push_exp(3, 16'hF00F, 4'b0100, 1'b0);
    rsp_ready = 1'b1;
    #1;
    check("bp_release", {59'd0, rsp_valid, req_ready}, {59'd0, 1'b1, 4'b1000});
    step();
    req_valid[3] = 1'b0;
    wait_rsp("bp_req3_lat", 3);
    step();
    wait_idle("bp_idle");

    // Reset during WAIT abandons the operation.
    set_req(1, 16'd1, 16'd1, 4'b0000);
    step();
    req_valid[1] = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_reset("midrst");
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("midrst_norsp", {63'd0, rsp_valid}, 64'd0);
      step();
    end
    set_req(0, 16'd2, 16'd3, 4'b0000);
    set_req(2, 16'h0101, 16'd4, 4'b1100);
    push_exp(0, 16'd5, 4'b1000, 1'b0);
    push_exp(2, 16'h1010, 4'b0001, 1'b0);
    #1;
    check("post_rst_grant", {60'd0, req_ready}, 64'h1);
    step();
    req_valid[0] = 1'b0;
    n = 1;
    while (!req_ready[2] && n < 10) begin
      step();
      n++;
    end
    check("post_rst_next", 64'(n), 64'd3);
    step();
    req_valid[2] = 1'b0;
    wait_rsp("post_rst_lat", 3);
    step();
    wait_idle("post_rst_idle");

    step();
    check("sb_drain", 64'(sb.size()), 64'd0);
    check("alu_no_div0", 64'(div0_seen), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
